issue_hazard_ctrl: RTL and testbench

- Decode-stage issue controller for the LC-3b pipeline; sits directly upstream of register_scoreboard.
- Checks the decoded instruction's source/dest registers against the scoreboard ready vector and decides issue vs stall.
- Generates the scoreboard's decode-side write strobe (load_de, uses_dest0, index0) and the branch-shadow counter br_stall_count.
- Freezes on memory misses and flushes fetch after a taken branch.

---
 rtl/issue_hazard_ctrl_pkg.sv | 19 +
 rtl/issue_hazard_ctrl_operand_ready_check.sv | 23 ++
 rtl/issue_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_issue_hazard_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared LC-3b decode/issue types: register index, issue FSM states and
// the default branch-shadow length.
package lc3b_types;

    // Architectural register index (R0..R7).
    typedef logic [2:0] lc3b_reg;

    // Issue-controller states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RAW_WAIT = 2'd1,
        BR_WAIT  = 2'd2,
        FLUSH    = 2'd3
    } issue_state_t;

    // Cycles the branch-shadow counter is loaded with when a branch issues.
    localparam int BR_SHADOW_DEFAULT = 2;

endpackage

// File: rtl/issue_hazard_ctrl_operand_ready_check.sv
// Operand readiness: selects each used register's ready bit from the
// scoreboard vector and masks out operands the instruction does not touch.
module operand_ready_check
    import lc3b_types::*;
(
    input  logic [7:0] reg_ready,
    input  lc3b_reg    sr1,
    input  lc3b_reg    sr2,
    input  lc3b_reg    dr,
    input  logic       uses_sr1,
    input  logic       uses_sr2,
    input  logic       uses_dr,
    output logic       ops_ok
);

    // The dest check blocks WAW so a register never has two writes pending.
    always_comb begin
        ops_ok = (!uses_sr1 || reg_ready[sr1])
              && (!uses_sr2 || reg_ready[sr2])
              && (!uses_dr  || reg_ready[dr]);
    end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Decode-stage issue controller: decides issue vs stall against the
// register scoreboard, drives the scoreboard's decode-side write strobe,
// holds the branch shadow and flushes fetch after a taken branch.
module issue_hazard_ctrl
    import lc3b_types::*;
#(
    parameter int BR_SHADOW = BR_SHADOW_DEFAULT,
    parameter int CNT_W     = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             de_valid,
    input  lc3b_reg          de_sr1,
    input  lc3b_reg          de_sr2,
    input  lc3b_reg          de_dr,
    input  logic             de_uses_sr1,
    input  logic             de_uses_sr2,
    input  logic             de_uses_dr,
    input  logic             de_is_branch,
    input  logic [7:0]       reg_ready,
    input  logic             mem_miss_a,
    input  logic             mem_miss_b,
    input  logic             br_resolved,
    input  logic             br_taken,
    output logic             load_de,
    output logic             uses_dest0,
    output lc3b_reg          index0,
    output logic [CNT_W-1:0] br_stall_count,
    output logic             stall_fetch,
    output logic             insert_bubble,
    output logic             flush
);

    issue_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             ops_ok;
    logic             miss;

    operand_ready_check u_ops (
        .reg_ready (reg_ready),
        .sr1       (de_sr1),
        .sr2       (de_sr2),
        .dr        (de_dr),
        .uses_sr1  (de_uses_sr1),
        .uses_sr2  (de_uses_sr2),
        .uses_dr   (de_uses_dr),
        .ops_ok    (ops_ok)
    );

    // Issue decision and pipeline-control outputs.
    always_comb begin
        miss           = mem_miss_a || mem_miss_b;
        load_de        = de_valid && (state_q == RUN) && ops_ok && !miss
                      && (cnt_q == '0);
        stall_fetch    = miss || (de_valid && !load_de) || (state_q == BR_WAIT);
        insert_bubble  = !load_de;
        flush          = (state_q == FLUSH);
        uses_dest0     = de_valid && de_uses_dr;
        index0         = de_dr;
        br_stall_count = cnt_q;
    end

    // Next-state logic; a memory miss freezes everything except capture of
    // a taken branch that resolves while frozen.
    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        if (miss) begin
            if ((state_q == BR_WAIT) && br_resolved && br_taken) begin
                pend_d = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (load_de && de_is_branch) begin
                        state_d = BR_WAIT;
                        cnt_d   = CNT_W'(BR_SHADOW);
                    end else if (de_valid && !ops_ok) begin
                        state_d = RAW_WAIT;
                    end
                end
                RAW_WAIT: begin
                    // Wake-up only changes state; issue follows next cycle.
                    if (ops_ok || !de_valid) begin
                        state_d = RUN;
                    end
                end
                BR_WAIT: begin
                    if ((br_resolved && br_taken) || pend_q) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else if (br_resolved) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                FLUSH: begin
                    state_d = RUN;
                    pend_d  = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State, branch-shadow counter and pending-taken flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Self-checking bench for issue_hazard_ctrl: a vector table for single-cycle
// behaviour plus hand-written branch, miss and reset sequences. Expected
// outputs are queued when stimulus is applied and compared mid-cycle.
module tb_issue_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [2:0] sr1, sr2, dr;
        logic       u1, u2, ud, br;
        logic [7:0] rdy;
        logic       ma, mb, res, tkn;
    } in_t;

    typedef struct packed {
        logic       ld, ud0;
        logic [2:0] idx;
        logic [1:0] cnt;
        logic       sf, ib, fl;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       de_valid, de_uses_sr1, de_uses_sr2, de_uses_dr, de_is_branch;
    logic [2:0] de_sr1, de_sr2, de_dr;
    logic [7:0] reg_ready;
    logic       mem_miss_a, mem_miss_b, br_resolved, br_taken;
    logic       load_de, uses_dest0, stall_fetch, insert_bubble, flush;
    logic [2:0] index0;
    logic [1:0] br_stall_count;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    vec_t vecs[14];

    issue_hazard_ctrl #(.BR_SHADOW(2), .CNT_W(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .de_valid       (de_valid),
        .de_sr1         (de_sr1),
        .de_sr2         (de_sr2),
        .de_dr          (de_dr),
        .de_uses_sr1    (de_uses_sr1),
        .de_uses_sr2    (de_uses_sr2),
        .de_uses_dr     (de_uses_dr),
        .de_is_branch   (de_is_branch),
        .reg_ready      (reg_ready),
        .mem_miss_a     (mem_miss_a),
        .mem_miss_b     (mem_miss_b),
        .br_resolved    (br_resolved),
        .br_taken       (br_taken),
        .load_de        (load_de),
        .uses_dest0     (uses_dest0),
        .index0         (index0),
        .br_stall_count (br_stall_count),
        .stall_fetch    (stall_fetch),
        .insert_bubble  (insert_bubble),
        .flush          (flush)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(logic v, logic [2:0] s1, logic [2:0] s2,
                                  logic [2:0] d, logic u1, logic u2, logic ud,
                                  logic br, logic [7:0] rdy, logic ma,
                                  logic mb, logic res, logic tkn);
        mk_in = '{v, s1, s2, d, u1, u2, ud, br, rdy, ma, mb, res, tkn};
    endfunction

    function automatic exp_t mk_exp(logic ld, logic ud0, logic [2:0] idx,
                                    logic [1:0] cnt, logic sf, logic ib,
                                    logic fl);
        mk_exp = '{ld, ud0, idx, cnt, sf, ib, fl};
    endfunction

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input in_t v, input exp_t e);
        de_valid     = v.valid;
        de_sr1       = v.sr1;
        de_sr2       = v.sr2;
        de_dr        = v.dr;
        de_uses_sr1  = v.u1;
        de_uses_sr2  = v.u2;
        de_uses_dr   = v.ud;
        de_is_branch = v.br;
        reg_ready    = v.rdy;
        mem_miss_a   = v.ma;
        mem_miss_b   = v.mb;
        br_resolved  = v.res;
        br_taken     = v.tkn;
        exp_q.push_back(e);
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".load_de"},        8'(load_de),        8'(e.ld));
            check({tag, ".uses_dest0"},     8'(uses_dest0),     8'(e.ud0));
            check({tag, ".index0"},         8'(index0),         8'(e.idx));
            check({tag, ".br_stall_count"}, 8'(br_stall_count), 8'(e.cnt));
            check({tag, ".stall_fetch"},    8'(stall_fetch),    8'(e.sf));
            check({tag, ".insert_bubble"},  8'(insert_bubble),  8'(e.ib));
            check({tag, ".flush"},          8'(flush),          8'(e.fl));
        end
    endtask

    // One cycle: drive just after the rising edge, compare on the falling edge.
    task automatic step(input string tag, input in_t v, input exp_t e);
        @(posedge clk);
        #1;
        apply(v, e);
        @(negedge clk);
        compare_pop(tag);
    endtask

    initial begin : main
        in_t idle, nxt, brn;
        idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0);
        nxt  = mk_in(1, 1, 2, 3, 1, 1, 1, 0, 8'hFF, 0, 0, 0, 0);
        brn  = mk_in(1, 3, 0, 0, 1, 0, 0, 1, 8'hFF, 0, 0, 0, 0);

        vecs[0]  = '{idle, mk_exp(0, 0, 0, 0, 0, 1, 0)};
        vecs[1]  = '{mk_in(1, 2, 3, 1, 1, 1, 1, 0, 8'hFF, 0, 0, 0, 0), mk_exp(1, 1, 1, 0, 0, 0, 0)};
        vecs[2]  = '{mk_in(1, 2, 3, 4, 1, 1, 1, 0, 8'hFB, 0, 0, 0, 0), mk_exp(0, 1, 4, 0, 1, 1, 0)};
        vecs[3]  = '{mk_in(1, 2, 3, 4, 1, 1, 1, 0, 8'hFB, 0, 0, 0, 0), mk_exp(0, 1, 4, 0, 1, 1, 0)};
        vecs[4]  = '{mk_in(1, 2, 3, 4, 1, 1, 1, 0, 8'hFF, 0, 0, 0, 0), mk_exp(0, 1, 4, 0, 1, 1, 0)};
        vecs[5]  = '{mk_in(1, 2, 3, 4, 1, 1, 1, 0, 8'hFF, 0, 0, 0, 0), mk_exp(1, 1, 4, 0, 0, 0, 0)};
        vecs[6]  = '{mk_in(1, 0, 0, 1, 0, 0, 1, 0, 8'hFD, 0, 0, 0, 0), mk_exp(0, 1, 1, 0, 1, 1, 0)};
        vecs[7]  = '{mk_in(1, 0, 0, 1, 0, 0, 1, 0, 8'hFD, 0, 0, 0, 0), mk_exp(0, 1, 1, 0, 1, 1, 0)};
        vecs[8]  = '{mk_in(1, 0, 0, 1, 0, 0, 1, 0, 8'hFF, 0, 0, 0, 0), mk_exp(0, 1, 1, 0, 1, 1, 0)};
        vecs[9]  = '{mk_in(1, 0, 0, 1, 0, 0, 1, 0, 8'hFF, 0, 0, 0, 0), mk_exp(1, 1, 1, 0, 0, 0, 0)};
        vecs[10] = '{mk_in(1, 2, 7, 5, 0, 1, 1, 0, 8'hFB, 0, 0, 0, 0), mk_exp(1, 1, 5, 0, 0, 0, 0)};
        vecs[11] = '{mk_in(1, 0, 1, 6, 1, 1, 1, 0, 8'hFF, 1, 0, 0, 0), mk_exp(0, 1, 6, 0, 1, 1, 0)};
        vecs[12] = '{mk_in(1, 2, 0, 6, 1, 0, 1, 0, 8'hFB, 0, 1, 0, 0), mk_exp(0, 1, 6, 0, 1, 1, 0)};
        vecs[13] = '{mk_in(1, 2, 0, 6, 1, 0, 1, 0, 8'hFF, 0, 0, 0, 0), mk_exp(1, 1, 6, 0, 0, 0, 0)};

        // Reset state.
        reset_n = 1'b0;
        apply(idle, mk_exp(0, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
        compare_pop("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Single-cycle issue, RAW/WAW stalls, operand masking, miss freeze.
        for (int i = 0; i < 14; i++) begin
            step($sformatf("vec%0d", i), vecs[i].i, vecs[i].e);
        end

        // Taken branch: shadow 2,1,0, saturate at 0, then one-cycle flush.
        step("br_issue", brn, mk_exp(1, 0, 0, 0, 0, 0, 0));
        step("br_cnt2", nxt, mk_exp(0, 1, 3, 2, 1, 1, 0));
        step("br_cnt1", nxt, mk_exp(0, 1, 3, 1, 1, 1, 0));
        step("br_cnt0", nxt, mk_exp(0, 1, 3, 0, 1, 1, 0));
        step("br_sat0", nxt, mk_exp(0, 1, 3, 0, 1, 1, 0));
        nxt.res = 1'b1; nxt.tkn = 1'b1;
        step("br_resolve", nxt, mk_exp(0, 1, 3, 0, 1, 1, 0));
        nxt.res = 1'b0; nxt.tkn = 1'b0;
        step("br_flush", nxt, mk_exp(0, 1, 3, 0, 1, 1, 1));
        step("br_after", nxt, mk_exp(1, 1, 3, 0, 0, 0, 0));

        // Not-taken branch resolves early; resolution is ignored in RUN.
        step("nt_issue", brn, mk_exp(1, 0, 0, 0, 0, 0, 0));
        nxt.res = 1'b1; nxt.tkn = 1'b0;
        step("nt_resolve", nxt, mk_exp(0, 1, 3, 2, 1, 1, 0));
        nxt.tkn = 1'b1;
        step("nt_run_ign", nxt, mk_exp(1, 1, 3, 0, 0, 0, 0));
        nxt.res = 1'b0; nxt.tkn = 1'b0;
        step("nt_noflush", nxt, mk_exp(1, 1, 3, 0, 0, 0, 0));

        // D-side miss in BR_WAIT freezes the count; taken branch is deferred.
        step("ms_issue", brn, mk_exp(1, 0, 0, 0, 0, 0, 0));
        nxt.mb = 1'b1;
        step("ms_frz0", nxt, mk_exp(0, 1, 3, 2, 1, 1, 0));
        nxt.res = 1'b1; nxt.tkn = 1'b1;
        step("ms_frz1", nxt, mk_exp(0, 1, 3, 2, 1, 1, 0));
        nxt.res = 1'b0; nxt.tkn = 1'b0;
        step("ms_frz2", nxt, mk_exp(0, 1, 3, 2, 1, 1, 0));
        nxt.mb = 1'b0;
        step("ms_clear", nxt, mk_exp(0, 1, 3, 2, 1, 1, 0));
        step("ms_flush", nxt, mk_exp(0, 1, 3, 0, 1, 1, 1));
        step("ms_after", nxt, mk_exp(1, 1, 3, 0, 0, 0, 0));

        // Asynchronous reset in the middle of a branch shadow.
        step("rs_issue", brn, mk_exp(1, 0, 0, 0, 0, 0, 0));
        step("rs_cnt2", idle, mk_exp(0, 0, 0, 2, 1, 1, 0));
        step("rs_cnt1", idle, mk_exp(0, 0, 0, 1, 1, 1, 0));
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(mk_exp(0, 0, 0, 0, 0, 1, 0));
        compare_pop("rs_async");
        @(negedge clk);
        reset_n = 1'b1;
        step("rs_issue2", nxt, mk_exp(1, 1, 3, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
